// File: rtl/bus_txn_scheduler.sv
// Round-robin scheduler sharing one slave handshake port among NUM_REQ requesters.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   req_vld/req_rw    - per-requester level request and direction (1 = write)
//   req_wdata         - per-requester write data, slice i at [i*DATA_W +: DATA_W]
//   grant, done       - one-hot grant of the requester being served, completion pulse
//   rdata             - last read data, held until the next read completes
//   busy              - high whenever a transaction is in progress
//   slv_start/rw/req  - slave handshake strobes
//   data_bus          - shared tristate slave data bus
module bus_txn_scheduler #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned BAUD_TICKS = 2,
  parameter int unsigned DATA_W     = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_vld,
  input  logic [NUM_REQ-1:0]        req_rw,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        grant,
  output logic [NUM_REQ-1:0]        done,
  output logic [DATA_W-1:0]         rdata,
  output logic                      busy,
  output logic                      slv_start,
  output logic                      slv_rw,
  output logic                      slv_req,
  inout  wire  [DATA_W-1:0]         data_bus
);

  localparam int unsigned PtrW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CntW = $clog2(BAUD_TICKS + 2);
  localparam logic [CntW-1:0] XferLast = CntW'(BAUD_TICKS + 1);
  localparam logic [CntW-1:0] GapLast  = CntW'(BAUD_TICKS - 1);
  localparam logic [PtrW-1:0] LastIdx  = PtrW'(NUM_REQ - 1);

  typedef enum logic [2:0] {StIdle, StStart, StXfer, StGap, StDone} state_e;

  state_e              state_q, state_d;
  logic [PtrW-1:0]     ptr_q, ptr_d;
  logic [PtrW-1:0]     win_q, win_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic                rw_q, rw_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [CntW-1:0]     cnt_q, cnt_d;

  logic                found;
  logic [PtrW-1:0]     win_idx;

  // Search from the pointer upward with wrap-around; first hit wins.
  always_comb begin
    int unsigned idx;
    found   = 1'b0;
    win_idx = '0;
    idx     = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = (32'(ptr_q) + i) % NUM_REQ;
      if (!found && req_vld[PtrW'(idx)]) begin
        found   = 1'b1;
        win_idx = PtrW'(idx);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    grant_d = grant_q;
    rw_d    = rw_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q + 1'b1;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          state_d          = StStart;
          win_d            = win_idx;
          grant_d          = '0;
          grant_d[win_idx] = 1'b1;
          rw_d             = req_rw[win_idx];
          wdata_d          = req_wdata[win_idx*DATA_W +: DATA_W];
        end
      end
      StStart: begin
        state_d = StXfer;
        cnt_d   = '0;
      end
      StXfer: begin
        if (cnt_q == XferLast) begin
          if (!rw_q) rdata_d = data_bus;
          state_d = StGap;
          cnt_d   = '0;
        end
      end
      StGap: begin
        if (cnt_q == GapLast) state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
        grant_d = '0;
        ptr_d   = (win_q == LastIdx) ? '0 : win_q + 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      win_q   <= '0;
      grant_q <= '0;
      rw_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      grant_q <= grant_d;
      rw_q    <= rw_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs decode only registered state, so nothing combinational leaks from inputs.
  assign grant     = grant_q;
  assign done      = (state_q == StDone) ? grant_q : '0;
  assign rdata     = rdata_q;
  assign busy      = (state_q != StIdle);
  assign slv_start = (state_q == StStart);
  assign slv_req   = (state_q == StXfer);
  assign slv_rw    = rw_q;
  assign data_bus  = (state_q == StXfer && rw_q) ? wdata_q : {DATA_W{1'bz}};

endmodule

// File: tb/tb_bus_txn_scheduler.sv
module tb_bus_txn_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_vld, req_rw;
  logic [15:0] req_wdata;
  logic [3:0]  grant, done, rdata;
  logic        busy, slv_start, slv_rw, slv_req;
  tri1  [3:0]  data_bus;  // pulled high: reads 4'hF when nobody drives
  logic [3:0]  slv_val;

  // Bench slave answers reads during the request phase.
  assign data_bus = (slv_req && !slv_rw) ? slv_val : 4'bzzzz;

  always #5 clk = ~clk;

  bus_txn_scheduler dut (
    .clk       (clk),
    .rst       (rst),
    .req_vld   (req_vld),
    .req_rw    (req_rw),
    .req_wdata (req_wdata),
    .grant     (grant),
    .done      (done),
    .rdata     (rdata),
    .busy      (busy),
    .slv_start (slv_start),
    .slv_rw    (slv_rw),
    .slv_req   (slv_req),
    .data_bus  (data_bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [3:0]  vld;
    logic [3:0]  rw;
    logic [15:0] wd;
    logic [3:0]  grant;
    logic [3:0]  done;
    logic        busy;
    logic        start;
    logic        req;
    logic        srw;
    logic [3:0]  bus;
    logic [3:0]  rdata;
  } vec_t;

  function automatic vec_t mk(input logic [3:0] vld, input logic [3:0] rw,
                              input logic [15:0] wd, input logic [3:0] g,
                              input logic [3:0] d, input logic b, input logic s,
                              input logic r, input logic w, input logic [3:0] bus,
                              input logic [3:0] rd);
    vec_t v;
    v.vld = vld; v.rw = rw; v.wd = wd; v.grant = g; v.done = d; v.busy = b;
    v.start = s; v.req = r; v.srw = w; v.bus = bus; v.rdata = rd;
    return v;
  endfunction

  task automatic wait_done(input string name, input logic [3:0] exp);
    int n = 0;
    while (done == 4'b0000 && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk(name, done, exp);
  endtask

  task automatic wait_xfer(input string name);
    int n = 0;
    while (!slv_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk(name, slv_req, 1'b1);
  endtask

  vec_t tbl[18];

  initial begin
    int         nrows;
    logic [3:0] prev_g;
    logic [3:0] gseq[5];
    int         gcyc[5];
    int         ng;
    int         cyc;
    logic [3:0] stray_done;

    // Single write from requester 1 (slice1 = A), then single read by requester 0.
    nrows = 0;
    tbl[nrows++] = mk(4'b0010, 4'b0010, 16'h00A0, 4'b0010, 4'b0, 1, 1, 0, 1, 4'hF, 4'h0);
    for (int i = 0; i < 4; i++)
      tbl[nrows++] = mk(4'b0010, 4'b0010, 16'h00A0, 4'b0010, 4'b0, 1, 0, 1, 1, 4'hA, 4'h0);
    for (int i = 0; i < 2; i++)
      tbl[nrows++] = mk(4'b0010, 4'b0010, 16'h00A0, 4'b0010, 4'b0, 1, 0, 0, 1, 4'hF, 4'h0);
    tbl[nrows++] = mk(4'b0010, 4'b0010, 16'h00A0, 4'b0010, 4'b0010, 1, 0, 0, 1, 4'hF, 4'h0);
    tbl[nrows++] = mk(4'b0000, 4'b0000, 16'h0000, 4'b0000, 4'b0, 0, 0, 0, 1, 4'hF, 4'h0);
    tbl[nrows++] = mk(4'b0001, 4'b0000, 16'h000C, 4'b0001, 4'b0, 1, 1, 0, 0, 4'hF, 4'h0);
    for (int i = 0; i < 4; i++)
      tbl[nrows++] = mk(4'b0001, 4'b0000, 16'h000C, 4'b0001, 4'b0, 1, 0, 1, 0, 4'h5, 4'h0);
    for (int i = 0; i < 2; i++)
      tbl[nrows++] = mk(4'b0001, 4'b0000, 16'h000C, 4'b0001, 4'b0, 1, 0, 0, 0, 4'hF, 4'h5);
    tbl[nrows++] = mk(4'b0001, 4'b0000, 16'h000C, 4'b0001, 4'b0001, 1, 0, 0, 0, 4'hF, 4'h5);
    tbl[nrows++] = mk(4'b0000, 4'b0000, 16'h0000, 4'b0000, 4'b0, 0, 0, 0, 0, 4'hF, 4'h5);

    slv_val   = 4'h5;
    rst       = 1'b1;
    req_vld   = '0;
    req_rw    = '0;
    req_wdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_grant", grant, 4'b0);
    chk("rst_done", done, 4'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_start", slv_start, 1'b0);
    chk("rst_req", slv_req, 1'b0);
    chk("rst_rw", slv_rw, 1'b0);
    chk("rst_rdata", rdata, 4'h0);
    chk("rst_bus", data_bus, 4'hF);
    rst = 1'b0;

    for (int i = 0; i < nrows; i++) begin
      req_vld   = tbl[i].vld;
      req_rw    = tbl[i].rw;
      req_wdata = tbl[i].wd;
      @(negedge clk);
      chk($sformatf("row%0d_grant", i), grant, tbl[i].grant);
      chk($sformatf("row%0d_done", i), done, tbl[i].done);
      chk($sformatf("row%0d_busy", i), busy, tbl[i].busy);
      chk($sformatf("row%0d_start", i), slv_start, tbl[i].start);
      chk($sformatf("row%0d_req", i), slv_req, tbl[i].req);
      chk($sformatf("row%0d_rw", i), slv_rw, tbl[i].srw);
      chk($sformatf("row%0d_bus", i), data_bus, tbl[i].bus);
      chk($sformatf("row%0d_rdata", i), rdata, tbl[i].rdata);
    end

    // Pointer is 1: requesters 0 and 3 compete, 3 is next in rotation.
    req_vld = 4'b1001; req_rw = 4'b1001; req_wdata = 16'h6006;
    wait_done("rr_skip_done", 4'b1000);
    req_vld = '0;
    @(negedge clk);
    chk("rdata_hold", rdata, 4'h5);
    chk("idle_after_rr", busy, 1'b0);

    // Served 3, pointer wrapped to 0: requester 1 beats 3.
    req_vld = 4'b1010; req_rw = 4'b1010; req_wdata = 16'h8020;
    wait_done("wrap_done", 4'b0010);
    req_vld = '0;
    @(negedge clk);

    // Contention from a fresh reset: 0,1,2,3,0 with a 9-cycle period.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    req_vld = 4'b1111; req_rw = 4'b1111; req_wdata = 16'h4321;
    prev_g = '0; ng = 0; cyc = 0;
    while (ng < 5 && cyc < 80) begin
      @(negedge clk);
      cyc++;
      chk("onehot", $countones(grant) <= 1, 1'b1);
      if (done != 4'b0000) chk("done_align", done, grant);
      if (grant != 4'b0000 && prev_g == 4'b0000) begin
        gseq[ng] = grant;
        gcyc[ng] = cyc;
        ng++;
      end
      prev_g = grant;
    end
    chk("cont_count", ng, 5);
    req_vld = '0;
    wait_done("cont_last_done", 4'b0001);
    if (ng == 5) begin
      chk("cont_g0", gseq[0], 4'b0001);
      chk("cont_g1", gseq[1], 4'b0010);
      chk("cont_g2", gseq[2], 4'b0100);
      chk("cont_g3", gseq[3], 4'b1000);
      chk("cont_g4", gseq[4], 4'b0001);
      for (int i = 1; i < 5; i++) chk($sformatf("cont_period%0d", i), gcyc[i] - gcyc[i-1], 9);
    end
    @(negedge clk);
    chk("cont_idle", busy, 1'b0);

    // Pointer is 1 here; abort a write by requester 2 mid-XFER.
    req_vld = 4'b0100; req_rw = 4'b0100; req_wdata = 16'h0900;
    wait_xfer("abort_reach_xfer");
    @(negedge clk);
    chk("abort_bus_pre", data_bus, 4'h9);
    rst = 1'b1; req_vld = '0;
    @(negedge clk);
    chk("abort_grant", grant, 4'b0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 4'b0);
    chk("abort_req", slv_req, 1'b0);
    chk("abort_bus", data_bus, 4'hF);
    rst = 1'b0;
    stray_done = '0;
    repeat (12) begin
      @(negedge clk);
      stray_done |= done;
    end
    chk("abort_no_done", stray_done, 4'b0);
    // Pointer must be back at 0, so requester 0 beats 2.
    req_vld = 4'b0101; req_rw = 4'b0000; req_wdata = '0;
    wait_done("post_abort_done", 4'b0001);
    req_vld = '0;
    @(negedge clk);

    // Winner withdraws and changes data mid-XFER; latched data stays on the bus.
    req_vld = 4'b0010; req_rw = 4'b0010; req_wdata = 16'h0070;
    wait_xfer("wd_reach_xfer");
    chk("wd_bus0", data_bus, 4'h7);
    req_vld = '0; req_wdata = 16'h0030;
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("wd_bus%0d", i), data_bus, 4'h7);
    end
    wait_done("wd_done", 4'b0010);
    @(negedge clk);
    chk("wd_idle", busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bus_txn_scheduler.md
Name: bus_txn_scheduler

Overview:
Round-robin scheduler that shares a single slave handshake port (start/rw/req plus a 4-bit tristate data_bus) among NUM_REQ local requesters. It grants one requester at a time and sequences the slave through its start, request, transfer and done phases with baud-tick timing. For writes it drives data_bus; for reads it captures data_bus and returns the data to the granted requester. It sits between the requester logic and the slave bus interface.

Parameters:
NUM_REQ, 4, number of requesters (1..8)
BAUD_TICKS, 2, slave baud-tick length in clk cycles (>=1)
DATA_W, 4, data_bus width

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
req_vld  input  NUM_REQ  per-requester transfer request, level, held until its done pulse
req_rw  input  NUM_REQ  per-requester direction: 1 = write to slave, 0 = read from slave
req_wdata  input  NUM_REQ*DATA_W  per-requester write data; requester i uses slice [i*DATA_W +: DATA_W]
grant  output  NUM_REQ  one-hot, registered; identifies the requester currently being served
done  output  NUM_REQ  one-cycle completion pulse to the granted requester
rdata  output  DATA_W  last read data; held until the next read completes
busy  output  1  high in every state except IDLE
slv_start  output  1  slave start strobe
slv_rw  output  1  slave direction, equal to the latched rw
slv_req  output  1  slave transfer request
data_bus  inout  DATA_W  shared slave data bus

Behaviour:
- States: IDLE, START, XFER, GAP, DONE. All outputs are decoded from the registered state and registered fields; there are no combinational paths from inputs to outputs.
- Reset (synchronous; rst sampled high at a clk edge):
  - state returns to IDLE.
  - grant, done, rdata, slv_start, slv_rw, slv_req and busy all go to 0.
  - data_bus is released to high-Z.
  - the round-robin pointer returns to 0.
  - rst asserted mid-transaction aborts the transaction immediately; no done pulse is issued.
- IDLE: when req_vld != 0, select a winner by round-robin, searching from the pointer upward with wrap-around.
  - On the next edge: state becomes START, grant[winner] is set, and req_rw[winner] and the winner's req_wdata slice are latched.
  - When req_vld == 0, state stays IDLE.
- START: lasts 1 cycle with slv_start=1, then state becomes XFER.
- XFER: lasts BAUD_TICKS+2 cycles, counted by a tick counter that is cleared on entry.
  - slv_req=1 and slv_rw=latched rw for the whole state.
  - When rw=1, data_bus is driven with the latched wdata for every XFER cycle.
  - When rw=0, data_bus is high-Z and rdata captures data_bus on the last XFER cycle.
- GAP: lasts BAUD_TICKS cycles with slv_req=0, slv_start=0 and data_bus high-Z, giving the slave time to pass through its DONE phase.
- DONE: lasts 1 cycle with done[winner]=1.
  - On exit, grant is cleared, the pointer is set to winner+1 modulo NUM_REQ, and state returns to IDLE.
- Transaction length is 2*BAUD_TICKS+4 cycles from START through DONE, so 8 cycles at the default.
  - Back-to-back requests are spaced by one IDLE cycle, giving a 9-cycle period at default.
- data_bus is driven only in XFER with rw=1. It is high-Z in every other state and during reset.
- Once a grant is issued, changes to req_vld, req_rw or req_wdata are ignored until DONE.
  - If the winner drops req_vld mid-transaction, the transaction still completes and still pulses done.
- A new request arriving during busy waits for IDLE. A request that arrives in the same cycle as DONE is evaluated in the following IDLE cycle using the updated pointer.
- NUM_REQ=1: the pointer stays at 0 and the single requester is served repeatedly.
- At most one bit of grant is set at any time. done is only ever set at the same index as grant.

Test Plan:
- Reset then a single write: req_vld=4'b0010, req_rw=4'b0010, slice1=4'hA. Required: grant=4'b0010; slv_start high for 1 cycle; slv_req high for 4 cycles with data_bus=4'hA; 2 GAP cycles; done[1] pulses; busy falls.
- Single read: requester 0 with rw=0; bench slave drives data_bus=4'h5 during XFER. Required: rdata=4'h5 after XFER and held through later writes; data_bus is never driven by the DUT.
- Contention: all four req_vld held high. Required: grants follow 0,1,2,3,0 with a 9-cycle period; no double grant; each done aligns with its grant.
- Pointer wrap: after serving requester 3, assert requesters 1 and 3. Required: requester 1 is granted first.
- Reset mid-XFER during a write: assert rst. Required: the next cycle shows state IDLE, data_bus high-Z, grant=0, no done; a fresh request afterwards is granted starting from requester 0.
- Withdraw mid-transaction: the winner drops req_vld and changes req_wdata during XFER. Required: data_bus keeps the latched value and done still pulses.
